// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: one 128-bit state, LANES bytes per cycle through
// shared S-box lookups, result held behind a valid/ready handshake.
// Optional macro INV_SUB_BYTES_FWD_EN adds an enc port selecting the forward
// S-box so the same block can serve the encryption datapath.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic         enc,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Inverse S-box, entry 0 in the most significant byte
  localparam logic [0:255][7:0] INV_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

`ifdef INV_SUB_BYTES_FWD_EN
  // Forward S-box, only present when the encryption mode is built in
  localparam logic [0:255][7:0] FWD_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic enc_q;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [0:15][7:0] work, work_sub;   // byte 0 sits at bits [127:120]

  // Substitute the LANES bytes selected by the counter; the rest pass through
  always_comb begin
    work_sub = work;
    for (int l = 0; l < LANES; l++) begin
`ifdef INV_SUB_BYTES_FWD_EN
      work_sub[4'(int'(cnt) * LANES + l)] = enc_q ? FWD_TAB[work[4'(int'(cnt) * LANES + l)]]
                                                  : INV_TAB[work[4'(int'(cnt) * LANES + l)]];
`else
      work_sub[4'(int'(cnt) * LANES + l)] = INV_TAB[work[4'(int'(cnt) * LANES + l)]];
`endif
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (cnt == CW'(N - 1)) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and working register; reset drops any partial block
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      enc_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_data;
          cnt   <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
          enc_q <= enc;
`endif
        end
        BUSY: begin
          work <= work_sub;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five instances (LANES = 1,2,4,8,16) share the
// same stimulus; results are checked against constant vectors and against an
// S-box model derived from GF(2^8) inversion plus the AES affine map.
module tb_inv_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] in_data = '0;
`ifdef INV_SUB_BYTES_FWD_EN
  logic enc = 1'b0;
`endif
  logic [4:0] in_ready_v, out_valid_v;
  logic [4:0][127:0] out_data_v;

  int tests = 0;
  int fails = 0;

  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_seq #(.LANES(1 << g)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready_v[g]),
      .in_data(in_data),
`ifdef INV_SUB_BYTES_FWD_EN
      .enc(enc),
`endif
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready),
      .out_data(out_data_v[g])
    );
  end

  typedef struct {
    logic [127:0] din;
    logic         e;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] ref_blk(input logic [127:0] din, input logic e);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127 - 8*i -: 8] = e ? fwd_m[din[127 - 8*i -: 8]] : inv_m[din[127 - 8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Release a held result and check every instance is back in IDLE
  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 128'(in_ready_v), 128'h1f);
    chk("release_out_valid", 128'(out_valid_v), 128'h0);
    @(negedge clk); out_ready = 1'b0;
  endtask

  // Send one block; measure latency per instance, check data, then release.
  // noise keeps in_valid high with different data while the block is in flight.
  task automatic do_block(input logic [127:0] din, input logic e, input logic [127:0] exp, input bit noise);
    int lat[5];
`ifndef INV_SUB_BYTES_FWD_EN
    if (e) $fatal(1, "FAIL bench_config enc vector without forward mode");
`endif
    @(negedge clk);
    in_data = din; in_valid = 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
    enc = e;
`endif
    @(posedge clk); #1;
    if (noise) in_data = ~din; else in_valid = 1'b0;
    for (int g = 0; g < 5; g++) lat[g] = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 5; g++)
        if (out_valid_v[g] && lat[g] == 0) lat[g] = cyc;
    end
    in_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("latency_L%0d", 1 << g), 128'(lat[g]), 128'(16 >> g));
      chk($sformatf("data_L%0d", 1 << g), out_data_v[g], exp);
      chk($sformatf("in_ready_done_L%0d", 1 << g), 128'(in_ready_v[g]), 128'h0);
    end
    release_out();
  endtask

  initial begin
    logic [7:0] iv, s;
    logic [127:0] d;
    logic e;

    // Reference S-boxes from field inversion and the affine transform
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_m[x] = s;
      inv_m[s] = 8'(x);
    end

    vecs.push_back('{128'h0, 1'b0, {16{8'h52}}});
    vecs.push_back('{128'h637c777bf26b6fc53001672bfed7ab76, 1'b0, 128'h000102030405060708090a0b0c0d0e0f});
    vecs.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h52096ad53036a538bf40a39e81f3d7fb});
    vecs.push_back('{{16{8'h53}}, 1'b0, {16{8'h50}}});
`ifdef INV_SUB_BYTES_FWD_EN
    vecs.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 128'h637c777bf26b6fc53001672bfed7ab76});
    vecs.push_back('{{16{8'h53}}, 1'b1, {16{8'hed}}});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready_v), 128'h1f);
    chk("reset_out_valid", 128'(out_valid_v), 128'h0);
    for (int g = 0; g < 5; g++) chk("reset_out_data", out_data_v[g], 128'h0);
    @(negedge clk); rst = 1'b0;

    // Constant vectors
    for (int i = 0; i < vecs.size(); i++)
      do_block(vecs[i].din, vecs[i].e, vecs[i].exp, i == 1);

    // Result held under backpressure: all-0xFF block
    @(negedge clk); in_data = {16{8'hff}}; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (16) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 128'(out_valid_v), 128'h1f);
      chk("hold_in_ready", 128'(in_ready_v), 128'h0);
      for (int g = 0; g < 5; g++) chk("hold_out_data", out_data_v[g], {16{8'h7d}});
    end
    release_out();

    // Reset mid-block (LANES=4 counter at 2), then a clean block
    @(negedge clk); in_data = 128'hdeadbeef_01234567_89abcdef_55aa55aa; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    chk("rst_busy_in_ready", 128'(in_ready_v), 128'h1f);
    chk("rst_busy_out_valid", 128'(out_valid_v), 128'h0);
    do_block({16{8'h01}}, 1'b0, {16{8'h09}}, 1'b0);

    // Random blocks against the model
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_SUB_BYTES_FWD_EN
      e = 1'($urandom_range(0, 1));
`else
      e = 1'b0;
`endif
      do_block(d, e, ref_blk(d, e), i[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
